// File: rtl/traffic_source.sv
// NoC traffic source: a table of packet descriptors replayed round-robin as
// valid/ready flits until a programmed number of packets has been sent.
module traffic_source #(
   parameter int DEPTH   = 16,
   parameter int DEST_W  = 14,
   parameter int VC_W    = 2,
   parameter int NFLIT_W = 10,
   parameter int CNT_W   = 10,
   localparam int EW     = $clog2(DEPTH + 1),
   localparam int HW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         cmd_op,
   input  logic [CNT_W-1:0]   cmd_total,
   input  logic [DEST_W-1:0]  fill_dest,
   input  logic [VC_W-1:0]    fill_vc,
   input  logic [NFLIT_W-1:0] fill_nflits,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_head,
   output logic               out_tail,
   output logic [VC_W-1:0]    out_vc,
   output logic [DEST_W-1:0]  out_dest,
   output logic [NFLIT_W-1:0] out_seq,
   output logic [EW-1:0]      entries,
   output logic [CNT_W-1:0]   sent,
   output logic               full,
   output logic               fill_err,
   output logic               done
);
   localparam logic [2:0] OP_INIT = 3'd5;
   localparam logic [2:0] OP_FILL = 3'd6;

   typedef enum logic {IDLE, SEND} state_t;

   logic [DEST_W-1:0]  slot_dest_q [DEPTH];
   logic [VC_W-1:0]    slot_vc_q   [DEPTH];
   logic [NFLIT_W-1:0] slot_n_q    [DEPTH];

   state_t             state_q, state_d;
   logic [EW-1:0]      entries_q, entries_d;
   logic [CNT_W-1:0]   sent_q, sent_d, total_q, total_d;
   logic [HW-1:0]      head_q, head_d, head_nxt, load_idx;
   logic               vld_q, vld_d, hd_q, hd_d, tl_q, tl_d, err_q, err_d;
   logic [VC_W-1:0]    vc_q, vc_d;
   logic [DEST_W-1:0]  dest_q, dest_d;
   logic [NFLIT_W-1:0] seq_q, seq_d, n_q, n_d, n_fill;
   logic               load, do_fill;

   assign full     = (entries_q == EW'(DEPTH));
   assign do_fill  = (cmd_op == OP_FILL) && !full;
   assign n_fill   = (fill_nflits == '0) ? NFLIT_W'(1) : fill_nflits;
   // Rotation wraps over the entries loaded now; later fills join on a wrap.
   assign head_nxt = ((EW'(head_q) + EW'(1)) == entries_q) ? '0 : head_q + HW'(1);

   always_ff @(posedge clk) begin
      if (do_fill) begin
         slot_dest_q[entries_q[HW-1:0]] <= fill_dest;
         slot_vc_q[entries_q[HW-1:0]]   <= fill_vc;
         slot_n_q[entries_q[HW-1:0]]    <= n_fill;
      end
   end

   always_comb begin
      state_d   = state_q;
      entries_d = entries_q;
      sent_d    = sent_q;
      total_d   = total_q;
      head_d    = head_q;
      vld_d     = vld_q;
      hd_d      = hd_q;
      tl_d      = tl_q;
      vc_d      = vc_q;
      dest_d    = dest_q;
      seq_d     = seq_q;
      n_d       = n_q;
      err_d     = 1'b0;
      load      = 1'b0;
      load_idx  = head_q;

      if (cmd_op == OP_FILL) begin
         if (full) err_d = 1'b1;
         else      entries_d = entries_q + EW'(1);
      end

      case (state_q)
         IDLE: begin
            if (entries_q != '0 && sent_q < total_q) begin
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (vld_q && out_ready) begin
               if (!tl_q) begin
                  seq_d = seq_q + NFLIT_W'(1);
                  hd_d  = 1'b0;
                  tl_d  = (seq_q + NFLIT_W'(1)) == (n_q - NFLIT_W'(1));
               end else begin
                  sent_d = sent_q + CNT_W'(1);
                  head_d = head_nxt;
                  if (sent_q + CNT_W'(1) < total_q) begin
                     load     = 1'b1;
                     load_idx = head_nxt;
                  end else begin
                     state_d = IDLE;
                     vld_d   = 1'b0;
                     hd_d    = 1'b0;
                     tl_d    = 1'b0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         vld_d  = 1'b1;
         hd_d   = 1'b1;
         seq_d  = '0;
         vc_d   = slot_vc_q[load_idx];
         dest_d = slot_dest_q[load_idx];
         n_d    = slot_n_q[load_idx];
         tl_d   = (slot_n_q[load_idx] == NFLIT_W'(1));
      end

      // INIT wins over a same-cycle handshake and drops any flit in flight.
      if (cmd_op == OP_INIT) begin
         state_d   = IDLE;
         entries_d = '0;
         sent_d    = '0;
         head_d    = '0;
         total_d   = cmd_total;
         vld_d     = 1'b0;
         hd_d      = 1'b0;
         tl_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         entries_q <= '0;
         sent_q    <= '0;
         total_q   <= '0;
         head_q    <= '0;
         vld_q     <= 1'b0;
         hd_q      <= 1'b0;
         tl_q      <= 1'b0;
         vc_q      <= '0;
         dest_q    <= '0;
         seq_q     <= '0;
         n_q       <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         entries_q <= entries_d;
         sent_q    <= sent_d;
         total_q   <= total_d;
         head_q    <= head_d;
         vld_q     <= vld_d;
         hd_q      <= hd_d;
         tl_q      <= tl_d;
         vc_q      <= vc_d;
         dest_q    <= dest_d;
         seq_q     <= seq_d;
         n_q       <= n_d;
         err_q     <= err_d;
      end
   end

   assign out_valid = vld_q;
   assign out_head  = hd_q;
   assign out_tail  = tl_q;
   assign out_vc    = vc_q;
   assign out_dest  = dest_q;
   assign out_seq   = seq_q;
   assign entries   = entries_q;
   assign sent      = sent_q;
   assign fill_err  = err_q;
   assign done      = (sent_q >= total_q);
endmodule

// File: tb/tb_traffic_source.sv
// Directed bench for traffic_source: one task per scenario, inline checks.
module tb_traffic_source;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  cmd_op = 3'd0;
   logic [9:0]  cmd_total = '0;
   logic [13:0] fill_dest = '0;
   logic [1:0]  fill_vc = '0;
   logic [9:0]  fill_nflits = '0;
   logic        out_ready = 1'b0;
   logic        out_valid, out_head, out_tail, full, fill_err, done;
   logic [1:0]  out_vc;
   logic [13:0] out_dest;
   logic [9:0]  out_seq, sent;
   logic [4:0]  entries;

   int n_cmp = 0;
   int n_bad = 0;

   traffic_source #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_op(cmd_op), .cmd_total(cmd_total),
      .fill_dest(fill_dest), .fill_vc(fill_vc), .fill_nflits(fill_nflits),
      .out_valid(out_valid), .out_ready(out_ready), .out_head(out_head),
      .out_tail(out_tail), .out_vc(out_vc), .out_dest(out_dest), .out_seq(out_seq),
      .entries(entries), .sent(sent), .full(full), .fill_err(fill_err), .done(done)
   );

   always #5 clk = ~clk;

   // flit word: {head, tail, seq, vc, dest}
   function automatic logic [27:0] fw(input logic h, input logic t, input logic [9:0] s,
                                      input logic [1:0] v, input logic [13:0] d);
      return {h, t, s, v, d};
   endfunction

   task automatic do_cmd(input logic [2:0] op, input logic [9:0] tot, input logic [13:0] d,
                         input logic [1:0] v, input logic [9:0] n);
      cmd_op = op; cmd_total = tot; fill_dest = d; fill_vc = v; fill_nflits = n;
      @(posedge clk); #1;
      cmd_op = 3'd0;
   endtask

   task automatic test_reset;
      n_cmp++;
      if ({out_valid, out_head, out_tail, out_vc, out_dest, out_seq} !== '0) begin
         n_bad++; $display("FAIL reset_out: got %h want 0", {out_valid, out_head, out_tail, out_vc, out_dest, out_seq});
      end
      n_cmp++;
      if ({entries, sent, full, fill_err, done} !== {5'd0, 10'd0, 1'b0, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL reset_status: got e=%0d s=%0d f=%b err=%b d=%b", entries, sent, full, fill_err, done);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      logic [27:0] exp [6];
      int k = 0;
      for (int i = 0; i < 3; i++) begin
         exp[2*i]   = fw(1'b1, 1'b0, 10'd0, 2'd1, 14'd5);
         exp[2*i+1] = fw(1'b0, 1'b1, 10'd1, 2'd1, 14'd5);
      end
      out_ready = 1'b1;
      do_cmd(3'd5, 10'd3, 14'd0, 2'd0, 10'd0);
      do_cmd(3'd6, 10'd0, 14'd5, 2'd1, 10'd2);
      for (int c = 0; c < 40 && k < 6; c++) begin
         if (out_valid) begin
            n_cmp++;
            if (fw(out_head, out_tail, out_seq, out_vc, out_dest) !== exp[k]) begin
               n_bad++; $display("FAIL basic_flit%0d: got %h want %h", k, fw(out_head, out_tail, out_seq, out_vc, out_dest), exp[k]);
            end
            k++;
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (k != 6) begin n_bad++; $display("FAIL basic_count: got %0d want 6", k); end
      n_cmp++;
      if ({out_valid, sent, done} !== {1'b0, 10'd3, 1'b1}) begin
         n_bad++; $display("FAIL basic_end: got v=%b s=%0d d=%b want v=0 s=3 d=1", out_valid, sent, done);
      end
   endtask

   task automatic test_back_to_back;
      logic [27:0] exp [8];
      int k = 0, first = -1, last = -1;
      exp[0] = fw(1, 1, 10'd0, 2'd2, 14'd10);
      exp[1] = fw(1, 0, 10'd0, 2'd3, 14'd20);
      exp[2] = fw(0, 0, 10'd1, 2'd3, 14'd20);
      exp[3] = fw(0, 1, 10'd2, 2'd3, 14'd20);
      for (int i = 0; i < 4; i++) exp[4+i] = exp[i];
      out_ready = 1'b1;
      do_cmd(3'd5, 10'd4, 14'd0, 2'd0, 10'd0);
      do_cmd(3'd6, 10'd0, 14'd10, 2'd2, 10'd1);
      do_cmd(3'd6, 10'd0, 14'd20, 2'd3, 10'd3);
      for (int c = 0; c < 60 && k < 8; c++) begin
         if (out_valid) begin
            n_cmp++;
            if (fw(out_head, out_tail, out_seq, out_vc, out_dest) !== exp[k]) begin
               n_bad++; $display("FAIL b2b_flit%0d: got %h want %h", k, fw(out_head, out_tail, out_seq, out_vc, out_dest), exp[k]);
            end
            if (first < 0) first = c;
            last = c;
            k++;
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (k != 8 || last - first != 7) begin
         n_bad++; $display("FAIL b2b_gapless: got %0d flits over %0d cycles want 8 over 7", k, last - first);
      end
      n_cmp++;
      if ({out_valid, sent, done} !== {1'b0, 10'd4, 1'b1}) begin
         n_bad++; $display("FAIL b2b_end: got v=%b s=%0d d=%b want v=0 s=4 d=1", out_valid, sent, done);
      end
   endtask

   task automatic test_backpressure;
      int w = 0;
      out_ready = 1'b0;
      do_cmd(3'd5, 10'd1, 14'd0, 2'd0, 10'd0);
      do_cmd(3'd6, 10'd0, 14'd7, 2'd0, 10'd4);
      while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_start: got valid %b want 1", out_valid); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (fw(out_head, out_tail, out_seq, out_vc, out_dest) !== fw(0, 0, 10'd1, 2'd0, 14'd7) || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", i, out_valid, fw(out_head, out_tail, out_seq, out_vc, out_dest), fw(0, 0, 10'd1, 2'd0, 14'd7));
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_seq, out_tail} !== {10'd2, 1'b0}) begin n_bad++; $display("FAIL bp_seq2: got seq=%0d t=%b want 2/0", out_seq, out_tail); end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_seq, out_tail} !== {10'd3, 1'b1}) begin n_bad++; $display("FAIL bp_seq3: got seq=%0d t=%b want 3/1", out_seq, out_tail); end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, sent} !== {1'b0, 10'd1}) begin n_bad++; $display("FAIL bp_end: got v=%b s=%0d want 0/1", out_valid, sent); end
   endtask

   task automatic test_full;
      do_cmd(3'd5, 10'd0, 14'd0, 2'd0, 10'd0);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) begin
            n_cmp++;
            if (full !== 1'b0) begin n_bad++; $display("FAIL full_early: got %b want 0", full); end
         end
         do_cmd(3'd6, 10'd0, 14'(i), 2'd0, 10'd1);
      end
      n_cmp++;
      if ({full, entries, fill_err} !== {1'b1, 5'(DEPTH), 1'b0}) begin
         n_bad++; $display("FAIL full_set: got f=%b e=%0d err=%b want 1/%0d/0", full, entries, fill_err, DEPTH);
      end
      do_cmd(3'd6, 10'd0, 14'd99, 2'd0, 10'd1);
      n_cmp++;
      if ({fill_err, entries} !== {1'b1, 5'(DEPTH)}) begin
         n_bad++; $display("FAIL full_err: got err=%b e=%0d want 1/%0d", fill_err, entries, DEPTH);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (fill_err !== 1'b0) begin n_bad++; $display("FAIL full_err_pulse: got %b want 0", fill_err); end
   endtask

   task automatic test_abort;
      int w = 0;
      out_ready = 1'b1;
      do_cmd(3'd5, 10'd2, 14'd0, 2'd0, 10'd0);
      do_cmd(3'd6, 10'd0, 14'd9, 2'd1, 10'd4);
      while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, out_seq} !== {1'b1, 10'd1}) begin n_bad++; $display("FAIL abort_body: got v=%b seq=%0d want 1/1", out_valid, out_seq); end
      do_cmd(3'd5, 10'd0, 14'd0, 2'd0, 10'd0);
      n_cmp++;
      if ({out_valid, sent, entries} !== {1'b0, 10'd0, 5'd0}) begin
         n_bad++; $display("FAIL abort_init: got v=%b s=%0d e=%0d want 0/0/0", out_valid, sent, entries);
      end
      do_cmd(3'd5, 10'd2, 14'd0, 2'd0, 10'd0);
      do_cmd(3'd6, 10'd0, 14'd9, 2'd1, 10'd4);
      w = 0;
      while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, out_head, out_tail, out_vc, out_dest, out_seq, entries, sent, fill_err, done} !==
          {1'b0, 1'b0, 1'b0, 2'd0, 14'd0, 10'd0, 5'd0, 10'd0, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL abort_rst: got v=%b seq=%0d dest=%0d e=%0d s=%0d d=%b", out_valid, out_seq, out_dest, entries, sent, done);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_edge_cases;
      int w = 0;
      int seen = 0;
      out_ready = 1'b0;
      do_cmd(3'd5, 10'd1, 14'd0, 2'd0, 10'd0);
      do_cmd(3'd6, 10'd0, 14'd3, 2'd1, 10'd0);
      while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
      n_cmp++;
      if ({out_valid, fw(out_head, out_tail, out_seq, out_vc, out_dest)} !== {1'b1, fw(1, 1, 10'd0, 2'd1, 14'd3)}) begin
         n_bad++; $display("FAIL zero_nflit: got v=%b %h want v=1 %h", out_valid, fw(out_head, out_tail, out_seq, out_vc, out_dest), fw(1, 1, 10'd0, 2'd1, 14'd3));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, sent, done} !== {1'b0, 10'd1, 1'b1}) begin n_bad++; $display("FAIL zero_nflit_end: got v=%b s=%0d d=%b want 0/1/1", out_valid, sent, done); end
      do_cmd(3'd5, 10'd0, 14'd0, 2'd0, 10'd0);
      do_cmd(3'd6, 10'd0, 14'd4, 2'd0, 10'd2);
      for (int c = 0; c < 10; c++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if ({seen != 0, done, sent} !== {1'b0, 1'b1, 10'd0}) begin
         n_bad++; $display("FAIL total_zero: got valid_cycles=%0d d=%b s=%0d want 0/1/0", seen, done, sent);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_full();
      test_abort();
      test_edge_cases();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
